soc_system_pio_in_capture: RTL and testbench
============================================

// Module: soc_system_pio_in_capture
// PURPOSE
//  Avalon-MM slave input PIO; the inbound counterpart of the output PIO ports in soc_system.
//  Synchronises an external WIDTH-bit in_port and detects edges per bit.
//  Latches detected edges in a write-1-to-clear capture register and counts edge events.
//  Raises a level interrupt towards the HPS for masked, captured edges.
// PARAMETERS
//  WIDTH        8   in_port / data width (1..32)
//  SYNC_STAGES  2   synchroniser flops per bit (2..4)
//  EDGE_TYPE    0   0=rising, 1=falling, 2=any edge
//  CNT_WIDTH    16  event counter width (1..32), saturating
// PORTS
//  clk        in   1      system clock
//  reset      in   1      synchronous, active-high reset
//  address    in   2      word offset: 0 DATA, 1 EVCNT, 2 IRQMASK, 3 EDGECAP
//  chipselect in   1      slave select
//  write_n    in   1      active-low write strobe
//  writedata  in   32     write data
//  readdata   out  32     read data, zero-extended, 0 wait states, read latency 0
//  in_port    in   WIDTH  asynchronous external inputs
//  irq        out  1      level interrupt = |(edgecap & irqmask)
// BEHAVIOUR
//  - wr = chipselect & ~write_n; registers update on the rising clk edge.
//  - reset=1 at an edge: sync chain, prev, edgecap, irqmask, evcnt and warmup counter all go to 0.
//    readdata and irq read 0 from the next cycle; a reset mid-operation discards pending edges.
//  - Sync: in_port passes through SYNC_STAGES flops to give sync_q.
//    A value stable before edge t is readable at DATA after edge t+SYNC_STAGES-1.
//  - Edge detect: prev <= sync_q every cycle.
//    rise = sync_q & ~prev; fall = ~sync_q & prev; edge = rise | fall | both, per EDGE_TYPE.
//  - Warmup: after reset, edge is forced to 0 until SYNC_STAGES+1 cycles have elapsed.
//    Implemented as a small counter that saturates at done. An input held high through reset
//    therefore produces no spurious edge.
//  - EDGECAP: edgecap[i] <= edge[i] | (edgecap[i] & ~clr[i]).
//    clr = writedata[WIDTH-1:0] when wr and address==3. If a clear and a new edge hit the
//    same bit in the same cycle, the set wins.
//  - Edge latency: a stable change before edge t sets edgecap at edge t+SYNC_STAGES.
//    irq follows combinationally in the same cycle.
//  - IRQMASK: read/write, bits [WIDTH-1:0]. irq updates in the cycle after a mask write.
//  - EVCNT: +1 in each cycle where |edge, irrespective of mask; saturates at all-ones.
//    Any write to address 1 clears it. If the clear coincides with an edge, evcnt becomes 1.
//  - DATA: read-only; writes are ignored.
//  - readdata: combinational mux of address. Upper bits beyond WIDTH/CNT_WIDTH read 0.
//    chipselect does not gate readdata.
//  - Reads have no side effects.
// STRUCTURE
//  - soc_system_pio_pkg holds the register offsets (ADDR_DATA=0, ADDR_EVCNT=1, ADDR_IRQMASK=2,
//    ADDR_EDGECAP=3) and the EDGE_RISE/EDGE_FALL/EDGE_ANY encodings.
//  - Sub-module soc_system_bit_sync: a parameterised N-stage synchroniser with synchronous reset,
//    instantiated WIDTH bits wide.
//  - The top level holds prev/edge logic, warmup counter, registers, read mux and irq.
// TESTING (WIDTH=8, SYNC_STAGES=2, EDGE_TYPE=0, CNT_WIDTH=16 unless noted)
//  1 Hold in_port=8'hFF through reset, release, wait 10 cycles.
//    -> DATA=0xFF, EDGECAP=0, EVCNT=0, irq=0.
//  2 in_port 0x00->0x05 before edge t, IRQMASK=0x04.
//    -> DATA=0x05 after t+1; EDGECAP=0x05 after t+2; irq=1 in the same cycle; EVCNT=1.
//  3 Bit0 edge in the same cycle as a write of 0x01 to EDGECAP.
//    -> EDGECAP[0] remains 1; writing 0x01 next cycle clears it and irq drops.
//  4 EDGE_TYPE=2, toggle bit3 every 4 cycles 3 times.
//    -> EVCNT=3; then write addr1 on the cycle of a 4th edge -> EVCNT=1.
//  5 CNT_WIDTH=2, produce 5 edge cycles.
//    -> EVCNT=3 (saturated); DATA write 0xAA ignored; reads of bits [31:8] = 0.
//  6 Assert reset with EDGECAP=0xFF, IRQMASK=0xFF, irq=1.
//    -> all registers read 0 and irq=0 after the reset edge.

Source files
------------

// File: rtl/soc_system_pio_pkg.sv
// Shared register map and edge-type encodings for the soc_system input PIO.
package soc_system_pio_pkg;

    localparam logic [1:0] ADDR_DATA    = 2'd0;
    localparam logic [1:0] ADDR_EVCNT   = 2'd1;
    localparam logic [1:0] ADDR_IRQMASK = 2'd2;
    localparam logic [1:0] ADDR_EDGECAP = 2'd3;

    localparam int unsigned EDGE_RISE = 0;
    localparam int unsigned EDGE_FALL = 1;
    localparam int unsigned EDGE_ANY  = 2;

endpackage

// File: rtl/soc_system_bit_sync.sv
// N-stage multi-bit synchroniser with synchronous active-high reset.
module soc_system_bit_sync #(
    parameter int unsigned WIDTH  = 1,
    parameter int unsigned STAGES = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] stage_q [STAGES];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < STAGES; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= d_i;
            for (int i = 1; i < STAGES; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign q_o = stage_q[STAGES-1];

endmodule

// File: rtl/soc_system_pio_in_capture.sv
// Avalon-MM input PIO: synchronised inputs, per-bit edge capture (W1C), saturating
// edge-event counter and a masked level interrupt.
module soc_system_pio_in_capture
    import soc_system_pio_pkg::*;
#(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned EDGE_TYPE   = 0,
    parameter int unsigned CNT_WIDTH   = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);

    localparam int unsigned WarmDone = SYNC_STAGES + 1;
    localparam int unsigned WarmW    = $clog2(WarmDone + 1);

    logic [WIDTH-1:0]     sync_q;
    logic [WIDTH-1:0]     prev_q;
    logic [WIDTH-1:0]     edgecap_q, edgecap_d;
    logic [WIDTH-1:0]     irqmask_q, irqmask_d;
    logic [CNT_WIDTH-1:0] evcnt_q, evcnt_d;
    logic [WarmW-1:0]     warm_q, warm_d;

    logic                 wr;
    logic                 warm_done;
    logic [WIDTH-1:0]     rise, fall, edge_raw, edge_det, clr;
    logic                 any_edge;
    logic                 unused_wdata;

    soc_system_bit_sync #(
        .WIDTH  (WIDTH),
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk_i (clk),
        .rst_i (reset),
        .d_i   (in_port),
        .q_o   (sync_q)
    );

    assign wr           = chipselect & ~write_n;
    assign warm_done    = (warm_q == WarmW'(WarmDone));
    assign unused_wdata = ^writedata;

    always_comb begin
        rise = sync_q & ~prev_q;
        fall = ~sync_q & prev_q;
        if (EDGE_TYPE == EDGE_FALL) begin
            edge_raw = fall;
        end else if (EDGE_TYPE == EDGE_ANY) begin
            edge_raw = rise | fall;
        end else begin
            edge_raw = rise;
        end
        // Suppress edges until the sync chain and prev hold real input data.
        edge_det = warm_done ? edge_raw : '0;
        any_edge = |edge_det;
    end

    always_comb begin
        warm_d    = warm_done ? warm_q : warm_q + WarmW'(1);
        clr       = (wr && address == ADDR_EDGECAP) ? writedata[WIDTH-1:0] : '0;
        edgecap_d = edge_det | (edgecap_q & ~clr);
        irqmask_d = (wr && address == ADDR_IRQMASK) ? writedata[WIDTH-1:0] : irqmask_q;
        evcnt_d   = evcnt_q;
        if (wr && address == ADDR_EVCNT) begin
            evcnt_d = any_edge ? CNT_WIDTH'(1) : '0;
        end else if (any_edge && evcnt_q != '1) begin
            evcnt_d = evcnt_q + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            prev_q    <= '0;
            edgecap_q <= '0;
            irqmask_q <= '0;
            evcnt_q   <= '0;
            warm_q    <= '0;
        end else begin
            prev_q    <= sync_q;
            edgecap_q <= edgecap_d;
            irqmask_q <= irqmask_d;
            evcnt_q   <= evcnt_d;
            warm_q    <= warm_d;
        end
    end

    always_comb begin
        readdata = '0;
        case (address)
            ADDR_DATA:    readdata[WIDTH-1:0]     = sync_q;
            ADDR_EVCNT:   readdata[CNT_WIDTH-1:0] = evcnt_q;
            ADDR_IRQMASK: readdata[WIDTH-1:0]     = irqmask_q;
            default:      readdata[WIDTH-1:0]     = edgecap_q;
        endcase
    end

    assign irq = |(edgecap_q & irqmask_q);

endmodule

// File: tb/tb_soc_system_pio_in_capture.sv
// Directed bench: default, any-edge and 2-bit-counter instances share the bus.
module tb_soc_system_pio_in_capture;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [7:0]  in_dut, in_any, in_sat;
    logic [31:0] rd_dut, rd_any, rd_sat;
    logic        irq_dut, irq_any, irq_sat;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    soc_system_pio_in_capture u_dut (
        .clk        (clk),
        .reset      (reset),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (rd_dut),
        .in_port    (in_dut),
        .irq        (irq_dut)
    );

    soc_system_pio_in_capture #(.EDGE_TYPE(2)) u_any (
        .clk        (clk),
        .reset      (reset),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (rd_any),
        .in_port    (in_any),
        .irq        (irq_any)
    );

    soc_system_pio_in_capture #(.CNT_WIDTH(2)) u_sat (
        .clk        (clk),
        .reset      (reset),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (rd_sat),
        .in_port    (in_sat),
        .irq        (irq_sat)
    );

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        chipselect = 1'b1;
        write_n    = 1'b0;
        address    = a;
        writedata  = d;
        @(posedge clk);
        #1;
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic set_addr(input logic [1:0] a);
        address = a;
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        in_dut = 8'hFF;
        in_any = 8'hFF;
        in_sat = 8'hFF;
        tick(3);
        reset = 1'b0;
        tick(10);
        set_addr(2'd0);
        checks++;
        if (rd_dut !== 32'h0000_00FF) begin
            errors++;
            $display("FAIL reset_data: got %h want %h", rd_dut, 32'h0000_00FF);
        end
        set_addr(2'd3);
        checks++;
        if (rd_dut !== 32'h0) begin
            errors++;
            $display("FAIL reset_edgecap: got %h want 0", rd_dut);
        end
        checks++;
        if (rd_any !== 32'h0) begin
            errors++;
            $display("FAIL reset_edgecap_any: got %h want 0", rd_any);
        end
        set_addr(2'd1);
        checks++;
        if (rd_dut !== 32'h0) begin
            errors++;
            $display("FAIL reset_evcnt: got %h want 0", rd_dut);
        end
        checks++;
        if (irq_dut !== 1'b0) begin
            errors++;
            $display("FAIL reset_irq: got %b want 0", irq_dut);
        end
    endtask

    task automatic test_edge_latency;
        in_dut = 8'h00;
        in_any = 8'h00;
        in_sat = 8'h00;
        tick(4);
        bus_write(2'd1, 32'h0);
        bus_write(2'd3, 32'hFF);
        bus_write(2'd2, 32'h04);
        in_dut = 8'h05;
        tick(1);
        set_addr(2'd0);
        checks++;
        if (rd_dut !== 32'h0) begin
            errors++;
            $display("FAIL lat_data_t: got %h want 0", rd_dut);
        end
        tick(1);
        checks++;
        if (rd_dut !== 32'h05) begin
            errors++;
            $display("FAIL lat_data_t1: got %h want 05", rd_dut);
        end
        set_addr(2'd3);
        checks++;
        if (rd_dut !== 32'h0 || irq_dut !== 1'b0) begin
            errors++;
            $display("FAIL lat_cap_t1: got %h/%b want 0/0", rd_dut, irq_dut);
        end
        tick(1);
        checks++;
        if (rd_dut !== 32'h05) begin
            errors++;
            $display("FAIL lat_cap_t2: got %h want 05", rd_dut);
        end
        checks++;
        if (irq_dut !== 1'b1) begin
            errors++;
            $display("FAIL lat_irq_t2: got %b want 1", irq_dut);
        end
        tick(1);
        set_addr(2'd1);
        checks++;
        if (rd_dut !== 32'h1) begin
            errors++;
            $display("FAIL lat_evcnt: got %h want 1", rd_dut);
        end
    endtask

    task automatic test_clear_vs_set;
        bus_write(2'd3, 32'h05);
        set_addr(2'd3);
        checks++;
        if (rd_dut !== 32'h0 || irq_dut !== 1'b0) begin
            errors++;
            $display("FAIL w1c_clear: got %h/%b want 0/0", rd_dut, irq_dut);
        end
        bus_write(2'd2, 32'h01);
        in_dut = 8'h04;
        tick(3);
        in_dut = 8'h05;
        tick(2);
        bus_write(2'd3, 32'h01);
        set_addr(2'd3);
        checks++;
        if (rd_dut !== 32'h01 || irq_dut !== 1'b1) begin
            errors++;
            $display("FAIL set_wins: got %h/%b want 01/1", rd_dut, irq_dut);
        end
        bus_write(2'd3, 32'h01);
        set_addr(2'd3);
        checks++;
        if (rd_dut !== 32'h0 || irq_dut !== 1'b0) begin
            errors++;
            $display("FAIL clear_after: got %h/%b want 0/0", rd_dut, irq_dut);
        end
        set_addr(2'd1);
        checks++;
        if (rd_dut !== 32'h2) begin
            errors++;
            $display("FAIL evcnt_two: got %h want 2", rd_dut);
        end
    endtask

    task automatic test_any_edge;
        bus_write(2'd1, 32'h0);
        for (int i = 0; i < 3; i++) begin
            in_any = in_any ^ 8'h08;
            tick(4);
        end
        set_addr(2'd1);
        checks++;
        if (rd_any !== 32'h3) begin
            errors++;
            $display("FAIL any_evcnt3: got %h want 3", rd_any);
        end
        set_addr(2'd3);
        checks++;
        if (rd_any !== 32'h08) begin
            errors++;
            $display("FAIL any_edgecap: got %h want 08", rd_any);
        end
        in_any = in_any ^ 8'h08;
        tick(2);
        bus_write(2'd1, 32'h0);
        tick(3);
        set_addr(2'd1);
        checks++;
        if (rd_any !== 32'h1) begin
            errors++;
            $display("FAIL any_clr_edge: got %h want 1", rd_any);
        end
    endtask

    task automatic test_saturate;
        bus_write(2'd1, 32'h0);
        for (int i = 0; i < 5; i++) begin
            in_sat = 8'h01;
            tick(4);
            in_sat = 8'h00;
            tick(4);
            if (i == 1) begin
                set_addr(2'd1);
                checks++;
                if (rd_sat !== 32'h2) begin
                    errors++;
                    $display("FAIL sat_evcnt2: got %h want 2", rd_sat);
                end
            end
        end
        set_addr(2'd1);
        checks++;
        if (rd_sat !== 32'h3) begin
            errors++;
            $display("FAIL sat_evcnt3: got %h want 3", rd_sat);
        end
        in_sat = 8'hFF;
        tick(4);
        bus_write(2'd0, 32'h0000_00AA);
        set_addr(2'd0);
        checks++;
        if (rd_sat !== 32'h0000_00FF) begin
            errors++;
            $display("FAIL data_ro: got %h want 000000ff", rd_sat);
        end
        bus_write(2'd2, 32'hFFFF_FFFF);
        set_addr(2'd2);
        checks++;
        if (rd_sat !== 32'h0000_00FF) begin
            errors++;
            $display("FAIL mask_upper: got %h want 000000ff", rd_sat);
        end
        set_addr(2'd1);
        checks++;
        if (rd_sat !== 32'h3) begin
            errors++;
            $display("FAIL sat_hold: got %h want 3", rd_sat);
        end
    endtask

    task automatic test_reset_mid;
        in_dut = 8'h00;
        tick(4);
        in_dut = 8'hFF;
        tick(4);
        bus_write(2'd2, 32'hFF);
        set_addr(2'd3);
        checks++;
        if (rd_dut !== 32'hFF || irq_dut !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset: got %h/%b want ff/1", rd_dut, irq_dut);
        end
        reset = 1'b1;
        tick(1);
        for (int a = 0; a < 4; a++) begin
            set_addr(2'(a));
            checks++;
            if (rd_dut !== 32'h0) begin
                errors++;
                $display("FAIL mid_reset_addr%0d: got %h want 0", a, rd_dut);
            end
        end
        checks++;
        if (irq_dut !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_irq: got %b want 0", irq_dut);
        end
        reset = 1'b0;
        tick(2);
    endtask

    initial begin
        address    = 2'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = 32'h0;
        test_reset();
        test_edge_latency();
        test_clear_vs_set();
        test_any_edge();
        test_saturate();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
